// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block from pipelined main memory,
// writes every returned word into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 miss_detected,
  input  logic [15:0]                          miss_address,
  input  logic                                 memory_data_valid,
  input  logic [15:0]                          memory_data,
  output logic                                 fsm_busy,
  output logic                                 memory_en,
  output logic [15:0]                          memory_address,
  output logic                                 write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0]   word_offset,
  output logic [15:0]                          cache_write_data,
  output logic                                 write_tag_array,
  output logic                                 fill_done
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W  = OFF_W + 1;
  localparam int unsigned LSB_W  = OFF_W + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << LSB_W) - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    issue_q, issue_d;
  logic [OFF_W-1:0]    recv_q, recv_d;

  // State and fill counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

  // Next state, counter updates and request/write strobes
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_d          = issue_q;
    recv_d           = recv_q;
    fsm_busy         = 1'b0;
    memory_en        = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_offset      = '0;
    cache_write_data = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    case (state_q)
      IDLE: begin
        // Stall starts in the miss cycle itself; held low while in reset.
        fsm_busy = miss_detected & rst_n;
        if (miss_detected) begin
          base_d  = miss_address & BLK_MASK;
          issue_d = '0;
          recv_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (issue_q < CNT_W'(WORDS_PER_BLOCK)) begin
          memory_en      = 1'b1;
          memory_address = base_q | ADDR_W'({issue_q[OFF_W-1:0], 1'b0});
          issue_d        = issue_q + CNT_W'(1);
        end
        // Completion is counted on returned words, so gaps are harmless.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_offset      = recv_q;
          cache_write_data = memory_data;
          recv_d           = recv_q + OFF_W'(1);
          if (recv_q == OFF_W'(WORDS_PER_BLOCK - 1)) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: cycle table for a nominal fill plus directed
// sequences for wrap, gaps, held miss, mid-fill reset and idle returns.
module tb_cache_fill_fsm;
  localparam int unsigned MEM_LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        fsm_busy, memory_en, write_data_array, write_tag_array, fill_done;
  logic [15:0] memory_address, cache_write_data;
  logic [2:0]  word_offset;

  always #5 clk = ~clk;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .fsm_busy(fsm_busy), .memory_en(memory_en), .memory_address(memory_address),
    .write_data_array(write_data_array), .word_offset(word_offset),
    .cache_write_data(cache_write_data), .write_tag_array(write_tag_array),
    .fill_done(fill_done)
  );

  typedef struct {
    logic miss; logic [15:0] addr;
    logic busy; logic en; logic [15:0] maddr;
    logic wr; logic [2:0] off; logic [15:0] wdata; logic tag; logic done;
  } vec_t;
  vec_t tv[14];

  int n_pass = 0, n_chk = 0, cyc_i = 0;

  // Memory model: request in cycle c returns its address as data in c+4.
  logic        pv[MEM_LATENCY];
  logic [15:0] pa[MEM_LATENCY];
  logic        last_en = 1'b0;
  logic [15:0] last_addr = '0;
  logic        use_model = 1'b1, man_v = 1'b0, rst_v = 1'b0;
  logic [15:0] man_d = '0;

  logic [15:0] req_a[32];  int req_cy[32];
  logic [2:0]  wr_off[32]; logic [15:0] wr_d[32]; int wr_cy[32];
  int req_n, wr_n, tag_n, tag_cy, done_cy, busy_lo, busy_n, val_n;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc_i, act, exp);
  endtask

  task automatic cyc(input logic miss, input logic [15:0] ma);
    @(posedge clk); #1;
    cyc_i++;
    for (int i = MEM_LATENCY - 1; i > 0; i--) begin
      pv[i] = pv[i-1]; pa[i] = pa[i-1];
    end
    pv[0] = last_en; pa[0] = last_addr;
    rst_n = rst_v;
    miss_detected = miss;
    miss_address  = ma;
    memory_data_valid = use_model ? pv[MEM_LATENCY-1] : man_v;
    memory_data       = use_model ? pa[MEM_LATENCY-1] : man_d;
    @(negedge clk);
    last_en = memory_en; last_addr = memory_address;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, int'(fsm_busy), 0);
    chk({tag, ".en"}, int'(memory_en), 0);
    chk({tag, ".maddr"}, int'(memory_address), 0);
    chk({tag, ".wr"}, int'(write_data_array), 0);
    chk({tag, ".off"}, int'(word_offset), 0);
    chk({tag, ".wdata"}, int'(cache_write_data), 0);
    chk({tag, ".tag"}, int'(write_tag_array), 0);
    chk({tag, ".done"}, int'(fill_done), 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < int'(MEM_LATENCY); i++) begin pv[i] = 1'b0; pa[i] = '0; end
    last_en = 1'b0; use_model = 1'b1; man_v = 1'b0;
    rst_v = 1'b0;
    cyc(1'b1, 16'h1234);
    chk_zero("reset");
    rst_v = 1'b1;
  endtask

  // Runs n cycles from cycle 0 and records what the DUT did.
  task automatic run(input int n, input logic [15:0] ma, input logic hold,
                     input logic [31:0] vsched, input logic first);
    int mk;
    mk = 0; req_n = 0; wr_n = 0; tag_n = 0; tag_cy = -1; done_cy = -1;
    busy_lo = -1; busy_n = 0; val_n = 0;
    use_model = (vsched == 32'h0);
    cyc_i = -1;
    for (int k = 0; k < n; k++) begin
      man_v = vsched[k];
      man_d = 16'h3000 + 16'(mk);
      if (vsched[k]) mk++;
      cyc((k == 0 && first) || hold, ma);
      if (memory_data_valid) val_n++;
      if (memory_en) begin req_a[req_n] = memory_address; req_cy[req_n] = cyc_i; req_n++; end
      if (write_data_array) begin
        wr_off[wr_n] = word_offset; wr_d[wr_n] = cache_write_data; wr_cy[wr_n] = cyc_i; wr_n++;
      end
      if (write_tag_array) begin tag_n++; tag_cy = cyc_i; end
      if (fill_done) done_cy = cyc_i;
      if (fsm_busy) busy_n++;
      else if (busy_lo < 0) busy_lo = cyc_i;
    end
  endtask

  initial begin
    //          miss  addr      busy  en    maddr     wr    off   wdata     tag   done
    tv[0]  = '{1'b1, 16'h1236, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 16'h1230, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 16'h1232, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 16'h1234, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 16'h1236, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h1238, 1'b0, 1'b0};
    tv[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 16'h123A, 1'b0, 1'b0};
    tv[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 16'h123C, 1'b0, 1'b0};
    tv[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 16'h123E, 1'b1, 1'b1};
    tv[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};

    // Nominal fill, cycle by cycle
    do_reset();
    cyc_i = -1;
    for (int i = 0; i < 14; i++) begin
      cyc(tv[i].miss, tv[i].addr);
      chk("t1.busy", int'(fsm_busy), int'(tv[i].busy));
      chk("t1.en", int'(memory_en), int'(tv[i].en));
      if (tv[i].en) chk("t1.maddr", int'(memory_address), int'(tv[i].maddr));
      chk("t1.wr", int'(write_data_array), int'(tv[i].wr));
      if (tv[i].wr) begin
        chk("t1.off", int'(word_offset), int'(tv[i].off));
        chk("t1.wdata", int'(cache_write_data), int'(tv[i].wdata));
      end
      chk("t1.tag", int'(write_tag_array), int'(tv[i].tag));
      chk("t1.done", int'(fill_done), int'(tv[i].done));
    end

    // Top-of-memory block must not wrap
    do_reset();
    run(14, 16'hFFFF, 1'b0, 32'h0, 1'b1);
    chk("t2.req_n", req_n, 8);
    for (int i = 0; i < 8; i++) chk("t2.maddr", int'(req_a[i]), 16'hFFF0 + 2 * i);
    chk("t2.wr_n", wr_n, 8);
    chk("t2.last_wdata", int'(wr_d[7]), 16'hFFFE);
    chk("t2.tag_cy", tag_cy, 12);
    chk("t2.busy_lo", busy_lo, 13);

    // Gaps after words 2 and 5: valids at 5,6,7,10,11,12,15,16
    do_reset();
    run(18, 16'h2000, 1'b0, 32'h0001_9CE0, 1'b1);
    chk("t3.req_n", req_n, 8);
    chk("t3.wr_n", wr_n, 8);
    for (int i = 0; i < 8; i++) chk("t3.off", int'(wr_off[i]), i);
    chk("t3.wdata7", int'(wr_d[7]), 16'h3007);
    chk("t3.wr_cy7", wr_cy[7], 16);
    chk("t3.tag_n", tag_n, 1);
    chk("t3.tag_cy", tag_cy, 16);
    chk("t3.done_cy", done_cy, 16);
    chk("t3.busy_lo", busy_lo, 17);

    // Miss held high: one fill, re-accept in cycle 13
    do_reset();
    run(15, 16'h0040, 1'b1, 32'h0, 1'b1);
    chk("t4.req_n", req_n, 9);
    chk("t4.req_cy7", req_cy[7], 8);
    chk("t4.req_cy8", req_cy[8], 14);
    chk("t4.req_a8", int'(req_a[8]), 16'h0040);
    chk("t4.tag_n", tag_n, 1);
    chk("t4.tag_cy", tag_cy, 12);
    chk("t4.busy_lo", busy_lo, -1);

    // Reset in cycle 7 of a fill, stale returns afterwards, then a clean fill
    do_reset();
    run(7, 16'h0100, 1'b0, 32'h0, 1'b1);
    rst_v = 1'b0;
    cyc(1'b1, 16'h0100);
    chk_zero("t5.rst");
    rst_v = 1'b1;
    run(4, 16'h0000, 1'b0, 32'h0, 1'b0);
    chk("t5.stale_val", val_n, 3);
    chk("t5.stale_wr", wr_n, 0);
    chk("t5.stale_tag", tag_n, 0);
    chk("t5.stale_busy", busy_n, 0);
    run(14, 16'h0108, 1'b0, 32'h0, 1'b1);
    chk("t5.wr_n", wr_n, 8);
    chk("t5.off0", int'(wr_off[0]), 0);
    chk("t5.wdata0", int'(wr_d[0]), 16'h0100);
    chk("t5.tag_cy", tag_cy, 12);

    // Returns in IDLE with no miss do nothing
    do_reset();
    run(4, 16'h0000, 1'b0, 32'h0000_000F, 1'b0);
    chk("t6.wr", wr_n, 0);
    chk("t6.tag", tag_n, 0);
    chk("t6.done", done_cy, -1);
    chk("t6.busy", busy_n, 0);
    chk("t6.en", req_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller shared by the instruction and data caches.
- On a cache miss it fetches the whole 16-byte block (8 words) from the 4-cycle pipelined main memory and writes each word into the cache data array. It then writes the tag.
- It holds the pipeline stall (PC_stall / IF_ID_stall path via the hazard logic) for the whole fill.
- It sits between the fetch/memory stage and main memory. Its activity is visible to the cpu_tb verification tasks as stall cycles.

Parameters:
- WORDS_PER_BLOCK, 8, number of 16-bit words in one cache block; block size is 2*WORDS_PER_BLOCK bytes.
- MEM_LATENCY, 4, cycles from a request with memory_en to the matching memory_data_valid; used for bench checks only, not by RTL.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_detected  in  1  cache lookup missed this cycle
- miss_address  in  16  byte address that missed
- memory_data_valid  in  1  memory returns one word this cycle
- memory_data  in  16  returned word
- fsm_busy  out  1  fill in progress; drives stall
- memory_en  out  1  read request to memory this cycle
- memory_address  out  16  byte address of the request
- write_data_array  out  1  write cache_write_data into the data array
- word_offset  out  3  word index within the block being written
- cache_write_data  out  16  equals memory_data
- write_tag_array  out  1  write the tag/valid for the block
- fill_done  out  1  one-cycle pulse on the final word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; issue_cnt=0; recv_cnt=0; base=0.
  - All outputs are 0, including a reset mid-fill.
  - Any in-flight memory returns after reset release are ignored (state is IDLE).
- States: IDLE, FILL.
- IDLE:
  - fsm_busy = miss_detected (combinational), so the stall begins in the same cycle as the miss.
  - On miss_detected: latch base = {miss_address[15:4], 4'h0}, clear both counters, next state FILL.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy = 1.
  - Requests: memory_en = (issue_cnt < 8). memory_address = base + {issue_cnt, 1'b0}. issue_cnt increments on every cycle with memory_en.
  - Requests therefore occupy 8 consecutive cycles, starting the first cycle in FILL.
  - Receive: when memory_data_valid=1, assert write_data_array=1 with word_offset = recv_cnt and cache_write_data = memory_data, then increment recv_cnt.
  - Gaps between valid words are tolerated; the counters, not fixed timing, decide completion.
  - Final word (valid with recv_cnt==7): assert write_data_array, write_tag_array and fill_done together in the same cycle. Next state is IDLE.
  - miss_detected is ignored during FILL; the stall keeps the requester from re-presenting it.
  - Extra memory_data_valid pulses after recv_cnt wraps are not possible, because the state leaves FILL.
- Address arithmetic: 16-bit, no carry into bits 15:4. Block 0xFFF0 yields 0xFFF0..0xFFFE, never wrapping into 0x0000.
- Latency: miss accepted in cycle 0 → requests in cycles 1..8 → data in cycles 5..12 (MEM_LATENCY=4) → tag write and fill_done in cycle 12 → fsm_busy=0 in cycle 13.
  - Miss penalty is 13 stall cycles including cycle 0.
- Back-to-back misses: a new miss_detected in the first IDLE cycle after a fill is accepted normally. There is no dead cycle.

Test Plan:
1. Reset, then miss at 0x1236 (cycle 0) with memory data = address → addresses 0x1230, 0x1232 .. 0x123E on cycles 1..8. write_data_array on cycles 5..12 with offsets 0..7. write_tag_array and fill_done only on cycle 12. fsm_busy high on cycles 0..12 and low on cycle 13.
2. Miss at 0xFFFF → requests 0xFFF0..0xFFFE; no address wraps to 0x0000.
3. memory_data_valid with 2-cycle gaps after words 2 and 5 → offsets stay contiguous 0..7. Tag write occurs only with the 8th valid; fsm_busy extends accordingly.
4. miss_detected held high throughout the fill of 0x0040 → a single fill (8 requests). Re-accept happens in cycle 13, starting a second fill at the same base.
5. rst_n low at cycle 7 of a fill → all outputs 0 immediately. Later valid pulses produce no writes. A new miss after release fills correctly from offset 0.
6. memory_data_valid pulsed in IDLE with no miss → no write_data_array, write_tag_array or fsm_busy.
